// File: rtl/modport_slave.sv
// -----------------------------------------------------------------------------
// modport_slave
//   Wishbone classic slave exposing a small bank of 32-bit registers.
//   Register 0 is a read-only ID word (g_id_value); registers 1..g_num_regs-1
//   are read/write with per-byte-lane write enables. Every request is
//   acknowledged one clock after the request edge; ack is forced low on the
//   cycle after it was high, so a master that keeps cyc/stb asserted sees
//   ack toggle 1,0,1,... and is never double-acknowledged. Out-of-range
//   writes are dropped but acknowledged; out-of-range reads return 0.
//
// Ports
//   clk_i    in   system clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   adr      in   word address (byte bits already stripped)
//   dat_o    in   write data from the master
//   sel      in   byte-lane selects, sel[0] -> dat_o[7:0]
//   cyc      in   bus cycle valid
//   stb      in   strobe
//   we       in   1 = write, 0 = read
//   ack      out  registered transfer acknowledge
//   dat_i    out  registered read data to the master
//   stall    out  always 0
// -----------------------------------------------------------------------------
module modport_slave #(
  parameter int                      g_data_width = 32,
  parameter int                      g_addr_width = 32,
  parameter int                      g_num_regs   = 16,
  parameter logic [g_data_width-1:0] g_id_value   = 32'hDEADBEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [g_addr_width-1:0]   adr,
  input  logic [g_data_width-1:0]   dat_o,
  input  logic [g_data_width/8-1:0] sel,
  input  logic                      cyc,
  input  logic                      stb,
  input  logic                      we,
  output logic                      ack,
  output logic [g_data_width-1:0]   dat_i,
  output logic                      stall
);

  localparam int idx_w   = $clog2(g_num_regs);
  localparam int lanes_c = g_data_width / 8;

  logic [g_data_width-1:0] regs_q [g_num_regs];
  logic [g_data_width-1:0] regs_d [g_num_regs];
  logic                    ack_q, ack_d;
  logic [g_data_width-1:0] dat_q, dat_d;

  logic             req;
  logic             in_range;
  logic [idx_w-1:0] idx;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    // A cycle where ack is already high is never a new request; this is what
    // produces the 1,0,1 pattern for a master that holds cyc/stb.
    req      = cyc & stb & ~ack_q;
    // In range when every address bit above the register index is zero.
    in_range = ((adr >> idx_w) == '0);
    idx      = adr[idx_w-1:0];

    ack_d  = req;
    dat_d  = dat_q;
    regs_d = regs_q;

    if (req && !we) begin
      if (!in_range) begin
        dat_d = '0;
      end else if (idx == '0) begin
        dat_d = g_id_value;
      end else begin
        dat_d = regs_q[idx];
      end
    end

    // Register 0 is the read-only ID word, so writes to it are dropped.
    if (req && we && in_range && (idx != '0)) begin
      for (int i = 0; i < lanes_c; i++) begin
        if (sel[i]) begin
          regs_d[idx][8*i +: 8] = dat_o[8*i +: 8];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      // NOTE: this register bank is a handful of flops, not a RAM macro, so
      // it is cleared by the asynchronous reset like any other state.
      for (int i = 0; i < g_num_regs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      regs_q <= regs_d;
    end
  end

  assign ack   = ack_q;
  assign dat_i = dat_q;
  assign stall = 1'b0;

endmodule

// File: tb/tb_modport_slave.sv
// -----------------------------------------------------------------------------
// tb_modport_slave
//   Directed self-checking bench for modport_slave with default parameters.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_modport_slave;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [31:0] dat_i;
  logic        stall;

  int checks = 0;
  int errors = 0;

  modport_slave dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .adr     (adr),
    .dat_o   (dat_o),
    .sel     (sel),
    .cyc     (cyc),
    .stb     (stb),
    .we      (we),
    .ack     (ack),
    .dat_i   (dat_i),
    .stall   (stall)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One classic single transfer: drive on the falling edge, expect ack one
  // clock after the request edge, release the bus, expect ack low next cycle.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_o = d; sel = s;
    check({tag, "_ack_before"}, {31'b0, ack}, 32'd0);
    @(posedge clk_i); #1;
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    rd = dat_i;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk_i); #1;
    check({tag, "_ack_after"}, {31'b0, ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] held;

    rst_n_i = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_o = '0; sel = '0;

    #2;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_i, 32'd0);
    check("stall", {31'b0, stall}, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // ID register read right after reset release.
    xfer("rd_id", 1'b0, 32'd0, 32'h0, 4'hF, rd);
    check("rd_id_dat", rd, 32'hDEADBEEF);

    // Full-word write and read-back.
    xfer("wr3_full", 1'b1, 32'd3, 32'h12345678, 4'hF, rd);
    check("wr_keeps_dat_i", dat_i, 32'hDEADBEEF);
    xfer("rd3_full", 1'b0, 32'd3, 32'h0, 4'h0, rd);
    check("rd3_full_dat", rd, 32'h12345678);

    // Byte-lane writes.
    xfer("wr3_b3", 1'b1, 32'd3, 32'hAABBCCDD, 4'b1000, rd);
    xfer("rd3_b3", 1'b0, 32'd3, 32'h0, 4'b0000, rd);
    check("rd3_b3_dat", rd, 32'hAA345678);
    xfer("wr3_b10", 1'b1, 32'd3, 32'h0000EEFF, 4'b0011, rd);
    xfer("rd3_b10", 1'b0, 32'd3, 32'h0, 4'b0101, rd);
    check("rd3_b10_dat", rd, 32'hAA34EEFF);

    // Read-only ID register.
    xfer("wr_id", 1'b1, 32'd0, 32'h0, 4'hF, rd);
    xfer("rd_id2", 1'b0, 32'd0, 32'h0, 4'hF, rd);
    check("rd_id2_dat", rd, 32'hDEADBEEF);

    // Out-of-range writes must not alias onto low registers.
    xfer("wr_oor100", 1'b1, 32'h100, 32'h55555555, 4'hF, rd);
    xfer("wr_oor103", 1'b1, 32'h103, 32'h66666666, 4'hF, rd);
    xfer("rd3_after_oor", 1'b0, 32'd3, 32'h0, 4'hF, rd);
    check("rd3_after_oor_dat", rd, 32'hAA34EEFF);
    xfer("rd_oor", 1'b0, 32'h100, 32'h0, 4'hF, rd);
    check("rd_oor_dat", rd, 32'h0);

    // Master holds cyc/stb: ack must alternate 1,0,1,0.
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("hold_ack%0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    check("hold_dat", dat_i, 32'hAA34EEFF);
    @(posedge clk_i); #1;
    check("hold_idle_ack", {31'b0, ack}, 32'd0);

    // Strobe without cyc is ignored.
    @(negedge clk_i);
    stb = 1'b1; we = 1'b1; adr = 32'd3; dat_o = 32'h0; sel = 4'hF;
    @(posedge clk_i); #1;
    check("stb_only_ack", {31'b0, ack}, 32'd0);
    stb = 1'b0; we = 1'b0;
    xfer("rd3_stb_only", 1'b0, 32'd3, 32'h0, 4'hF, rd);
    check("rd3_stb_only_dat", rd, 32'hAA34EEFF);

    // Reset asserted while ack is high for a write to register 5.
    held = dat_i;
    check("pre_rst_dat", held, 32'hAA34EEFF);
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd5; dat_o = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk_i); #1;
    check("mid_ack", {31'b0, ack}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, ack}, 32'd0);
    check("mid_rst_dat", dat_i, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    xfer("rd5_post_rst", 1'b0, 32'd5, 32'h0, 4'hF, rd);
    check("rd5_post_rst_dat", rd, 32'h0);
    xfer("rd3_post_rst", 1'b0, 32'd3, 32'h0, 4'hF, rd);
    check("rd3_post_rst_dat", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 Parameter g_data_width, default 32, data bus width; only 32 is supported.
REQ-002 Parameter g_addr_width, default 32, width of the word address bus.
REQ-003 Parameter g_num_regs, default 16, number of 32-bit registers; must be a power of two, 2..256.
REQ-004 Parameter g_id_value, default 32'hDEADBEEF, constant returned by register 0.
REQ-005 clk_i  in  1  single system clock, rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 adr  in  g_addr_width  Wishbone word address; byte address bits [1:0] are already stripped by the master.
REQ-008 dat_o  in  32  write data from the master.
REQ-009 sel  in  4  byte selects; sel[3] selects dat_o[31:24] and sel[0] selects dat_o[7:0].
REQ-010 cyc  in  1  bus cycle valid.
REQ-011 stb  in  1  strobe.
REQ-012 we  in  1  1 = write, 0 = read.
REQ-013 ack  out  1  transfer acknowledge, registered.
REQ-014 dat_i  out  32  read data to the master, registered.
REQ-015 stall  out  1  tied to 0; the block never stalls.

Function
REQ-016 The block SHALL be a Wishbone classic slave containing g_num_regs registers indexed by adr[log2(g_num_regs)-1:0].
REQ-017 Address decode: a request is in range when adr < g_num_regs; all other addresses are out of range.
REQ-018 A request is cyc & stb & !ack, sampled on the rising edge of clk_i.
REQ-019 On a request edge, ack SHALL be driven to 1 for exactly one cycle; latency is one clock from the request edge.
REQ-020 On the edge where ack is 1, ack SHALL return to 0 even if cyc & stb are still 1. This prevents a double-acknowledge while the master releases the bus.
REQ-021 A master holding cyc & stb across a continuous sequence SHALL receive ack on alternating cycles: 1, 0, 1, and so on.
REQ-022 Write request in range (we=1): for each byte lane with sel[i]=1, the register byte is updated on the request edge; unselected lanes are kept.
REQ-023 Write to register 0 SHALL be ignored, because register 0 is read-only.
REQ-024 Write request out of range SHALL be ignored, but still acknowledged.
REQ-025 Read request (we=0): dat_i is loaded on the request edge, together with ack, as follows:
- register 0 returns g_id_value;
- other in-range registers return the register value;
- out-of-range addresses return 0.
- sel SHALL be ignored for reads; all 32 bits are returned.
REQ-026 dat_i SHALL hold its last value when no read request occurs; it is not cleared after ack.
REQ-027 cyc=0 or stb=0 SHALL produce no register change and no ack; a strobe without cyc is ignored.
REQ-028 A write and a following read to the same register SHALL return the newly written value; there is no read-after-write hazard.
REQ-029 The block SHALL NOT generate err or rty; no error termination exists.

Reset
REQ-030 While rst_n_i=0, asynchronously: ack=0, dat_i=0, and registers 1..g_num_regs-1 = 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer: ack drops immediately and no register write occurs.
REQ-032 After rst_n_i deasserts, the first request is served on the next rising edge with normal latency.

Verification
REQ-033 Reset, then read adr 0 -> ack is high for exactly one cycle, one clock after the request edge, with dat_i=32'hDEADBEEF.
REQ-034 Write adr 3, data 32'h12345678, sel 4'b1111, then read adr 3 -> dat_i=32'h12345678.
REQ-035 Byte-lane write, after REQ-034:
- stimulus: write adr 3, data 32'hAABBCCDD, sel 4'b1000;
- read adr 3 -> dat_i=32'hAA345678;
- then write sel 4'b0011 with data 32'h0000EEFF;
- read adr 3 -> dat_i=32'hAA34EEFF.
REQ-036 Protected and out-of-range accesses:
- write adr 0 with 32'h0 -> ack occurs; a following read of adr 0 still returns 32'hDEADBEEF;
- write adr 32'h100 -> ack occurs and no register changes;
- read adr 32'h100 -> 32'h0.
REQ-037 Master holds cyc=stb=1 for 3 cycles after ack -> ack pattern is 1,0,1 and is never high on two consecutive cycles.
REQ-038 Reset mid-operation:
- stimulus: write adr 5 with 32'hCAFEF00D;
- assert rst_n_i=0 asynchronously between edges;
- required response: ack=0 and dat_i=0 immediately;
- after release, read adr 5 -> 32'h0.
